// File: rtl/debug_scan_master_if.sv
// ============================================================================
// Module      : debug_scan_master_if
// Description : Command/response stream plus virtual-JTAG pins of the scan master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debug_scan_master_if #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                cmd_ir_only;
    logic                abort;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic                busy;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, abort, rsp_ready, vji_tdo,
        output cmd_ready, rsp_valid, rsp_dr, busy, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, abort, rsp_ready, vji_tdo,
        input  cmd_ready, rsp_valid, rsp_dr, busy, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

`default_nettype wire

// File: rtl/debug_scan_master.sv
// ============================================================================
// Module      : debug_scan_master
// Description : Virtual-JTAG initiator: IR update plus optional DR scan per command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    debug_scan_master_if.master  bus
);
    localparam int DIV_W = $clog2(2 * TCK_DIV);
    localparam int CNT_W = $clog2(DR_WIDTH + 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_rise = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_high = DIV_W'(TCK_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UIR   = 3'd1,
        S_CDR   = 3'd2,
        S_SHIFT = 3'd3,
        S_UDR   = 3'd4,
        S_RTI   = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic ir_only_q, ir_only_d, aborted_q, aborted_d;
    logic tck_q, tck_d, tdi_q, tdi_d;
    logic uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
    logic rsp_valid_q, rsp_valid_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;

    logic w_accept, w_period_end, w_rise, w_abortable, w_abort_hit;

    assign w_accept     = bus.cmd_valid & cmd_ready_q;
    assign w_period_end = (state_q != S_IDLE) && (state_q != S_RESP) && (div_q == c_div_last);
    assign w_rise       = (state_q == S_SHIFT) && (div_q == c_div_rise);
    assign w_abortable  = state_q inside {S_UIR, S_CDR, S_SHIFT, S_UDR};
    assign w_abort_hit  = aborted_q | (bus.abort & w_abortable);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_UIR;
            S_UIR:   if (w_period_end) state_d = (w_abort_hit || ir_only_q) ? S_RTI : S_CDR;
            S_CDR:   if (w_period_end) state_d = w_abort_hit ? S_RTI : S_SHIFT;
            S_SHIFT: begin
                // An abort landing on the last bit still suppresses UDR.
                if (w_period_end) begin
                    if (w_abort_hit)              state_d = S_RTI;
                    else if (cnt_q == c_cnt_last) state_d = S_UDR;
                end
            end
            S_UDR:   if (w_period_end) state_d = S_RTI;
            S_RTI:   if (w_period_end) state_d = aborted_q ? S_IDLE : S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d       = ((state_q == S_IDLE) || (state_d == S_IDLE) || w_period_end) ? '0 : div_q + 1'b1;
        tck_d       = (state_d != S_IDLE) && (state_d != S_RESP) && (div_d >= c_div_high);
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ir_only_d   = ir_only_q;
        ir_in_d     = ir_in_q;
        if (w_accept) begin
            sr_d      = bus.cmd_dr;
            cnt_d     = '0;
            ir_only_d = bus.cmd_ir_only;
            ir_in_d   = bus.cmd_ir;
        end else if (w_rise) begin
            sr_d  = {bus.vji_tdo, sr_q[DR_WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
        end
        aborted_d = (state_d == S_IDLE) ? 1'b0 : w_abort_hit;
        // tdi is reloaded only at period starts so it stays put across the mid-period shift.
        if (state_d != S_SHIFT)                        tdi_d = 1'b0;
        else if ((state_q != S_SHIFT) || w_period_end) tdi_d = sr_q[0];
        else                                           tdi_d = tdi_q;
        uir_d       = (state_d == S_UIR);
        cdr_d       = (state_d == S_CDR);
        sdr_d       = (state_d == S_SHIFT);
        udr_d       = (state_d == S_UDR);
        rti_d       = (state_d == S_RTI);
        rsp_valid_d = rsp_valid_q;
        rsp_dr_d    = rsp_dr_q;
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
        if (state_q == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_dr_d    = ir_only_q ? '0 : sr_q;
        end
        cmd_ready_d = (state_d == S_IDLE) && !rsp_valid_d;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            sr_q        <= '0;
            ir_in_q     <= '0;
            rsp_dr_q    <= '0;
            ir_only_q   <= 1'b0;
            aborted_q   <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ir_in_q     <= ir_in_d;
            rsp_dr_q    <= rsp_dr_d;
            ir_only_q   <= ir_only_d;
            aborted_q   <= aborted_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dr    = rsp_dr_q;
    assign bus.busy      = busy_q;
    assign bus.vji_tck   = tck_q;
    assign bus.vji_tdi   = tdi_q;
    assign bus.vji_ir_in = ir_in_q;
    assign bus.vji_uir   = uir_q;
    assign bus.vji_cdr   = cdr_q;
    assign bus.vji_sdr   = sdr_q;
    assign bus.vji_udr   = udr_q;
    assign bus.vji_rti   = rti_q;

endmodule

`default_nettype wire
